// File: rtl/div_pkg.sv
// Shared types and helpers for the DIV/DIVU sequencer and its iteration core.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_ITER,
      S_FIX,
      S_DONE
   } state_t;

   // Magnitude of a signed operand; the most negative value maps to itself as unsigned.
   function automatic logic [DIV_WIDTH-1:0] twos_mag(input logic [DIV_WIDTH-1:0] v,
                                                     input logic                 is_signed);
      return (is_signed && v[DIV_WIDTH-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/div_iter_core.sv
// Unsigned non-restoring divide datapath: one quotient bit per step, no control of its own.
// The partial remainder keeps one extra bit; its MSB is the running remainder sign.
module div_iter_core
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quo_o,
   output logic [WIDTH-1:0] rem_o
);

   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   step_rem;

   always_comb begin
      shifted  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      step_rem = rem_q[WIDTH] ? shifted + {1'b0, dvs_q} : shifted - {1'b0, dvs_q};
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      if (load_i) begin
         rem_d = '0;
         quo_d = dividend_i;
         dvs_d = divisor_i;
      end else if (step_i) begin
         rem_d = step_rem;
         quo_d = {quo_q[WIDTH-2:0], ~step_rem[WIDTH]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
      end
   end

   assign quo_o = quo_q;
   // Final restore: a negative partial remainder gets the divisor added back.
   assign rem_o = rem_q[WIDTH] ? rem_q[WIDTH-1:0] + dvs_q : rem_q[WIDTH-1:0];

endmodule

// File: rtl/div_ctrl.sv
// MIPS DIV/DIVU sequencer: magnitude prep, WIDTH core iterations, sign fix, HI/LO write-back.
// Stalls MFHI/MFLO and new requests while busy; flush abandons the operation without writing.
module div_ctrl
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   input  logic             req_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             hilo_read,
   input  logic             flush,
   output logic             req_ready,
   output logic             stall,
   output logic             hilo_we,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             dbz
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             sgn_q, sgn_d;
   logic             negq_q, negq_d, negr_q, negr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             dbz_q, dbz_d;
   logic             accept;
   logic             core_load, core_step;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] core_quo, core_rem;

   assign a_mag = WIDTH'(twos_mag(DIV_WIDTH'(a_q), sgn_q));
   assign b_mag = WIDTH'(twos_mag(DIV_WIDTH'(b_q), sgn_q));

   assign req_ready = (state_q == S_IDLE) || (state_q == S_DONE);
   assign accept    = req_valid && req_ready && !flush;
   assign hilo_we   = (state_q == S_DONE) && !flush;
   assign stall     = ((req_valid || hilo_read) && (state_q inside {S_PREP, S_ITER, S_FIX}))
                    || (hilo_read && (state_q == S_DONE));

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sgn_d     = sgn_q;
      negq_d    = negq_q;
      negr_d    = negr_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dbz_d     = dbz_q;
      core_load = 1'b0;
      core_step = 1'b0;
      case (state_q)
         S_IDLE: if (accept) state_d = S_PREP;
         S_PREP: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               negq_d = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
               negr_d = sgn_q && a_q[WIDTH-1];
               cnt_d  = '0;
               if (b_q == '0) begin
                  // Divide by zero skips the core: HI echoes the raw dividend.
                  hi_d    = a_q;
                  lo_d    = '1;
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  core_load = 1'b1;
                  state_d   = S_ITER;
               end
            end
         end
         S_ITER: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               core_step = 1'b1;
               cnt_d     = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               hi_d    = negr_q ? -core_rem : core_rem;
               lo_d    = negq_q ? -core_quo : core_quo;
               dbz_d   = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = accept ? S_PREP : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (accept) begin
         a_d   = dividend;
         b_d   = divisor;
         sgn_d = req_signed;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

   div_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk_i      (clock),
      .rst_ni     (reset),
      .load_i     (core_load),
      .step_i     (core_step),
      .dividend_i (a_mag),
      .divisor_i  (b_mag),
      .quo_o      (core_quo),
      .rem_o      (core_rem)
   );

   assign hi  = hi_q;
   assign lo  = lo_q;
   assign dbz = dbz_q;

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencer that runs MIPS DIV and DIVU on a one-bit-per-cycle unsigned divide core.
- Accepts a request from the EX stage, takes operand magnitudes for signed ops, runs the core for WIDTH iterations and applies sign correction.
- Writes HI (remainder) and LO (quotient) back with a one-cycle write strobe.
- Stalls the pipeline while a result is pending, and supports pipeline flush.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  EX stage presents a DIV/DIVU.
- req_signed  in  1  1 = DIV, 0 = DIVU; sampled with req_valid.
- dividend  in  WIDTH  rs operand.
- divisor  in  WIDTH  rt operand.
- hilo_read  in  1  EX stage holds MFHI/MFLO.
- flush  in  1  pipeline flush; abandons the in-flight operation.
- req_ready  out  1  a request can be accepted this cycle.
- stall  out  1  freeze the front of the pipeline.
- hilo_we  out  1  one-cycle HI/LO write strobe.
- hi  out  WIDTH  remainder.
- lo  out  WIDTH  quotient.
- dbz  out  1  the last completed operation had divisor == 0.

Behaviour:
- Reset (reset = 0, asynchronous, valid in any state):
  - state goes to IDLE.
  - hi = 0, lo = 0, dbz = 0, hilo_we = 0.
  - The core is cleared.
- States: IDLE, PREP, ITER, FIX, DONE.
- Accept:
  - A request is accepted on a rising edge with req_valid & req_ready & ~flush.
  - req_ready = (state == IDLE) | (state == DONE), so back-to-back requests are allowed from DONE.
  - Operands and req_signed are captured on the accept edge.
- PREP (1 cycle):
  - If signed, record neg_q = sign(dividend) ^ sign(divisor) and neg_r = sign(dividend).
  - Replace each negative operand with its two's-complement magnitude; 0x80000000 stays 0x80000000 as an unsigned value.
  - If divisor == 0, go to DONE. Otherwise load the core and go to ITER.
- ITER:
  - Exactly WIDTH cycles; a count register runs 0 to WIDTH-1.
  - The core performs one non-restoring step per cycle.
  - Go to FIX when count == WIDTH-1.
- FIX (1 cycle):
  - Apply the core's final remainder restore.
  - Negate the quotient if neg_q; negate the remainder if neg_r.
  - Register the results into hi and lo. Go to DONE.
- DONE (1 cycle):
  - hilo_we = ~flush.
  - On the next edge, go to PREP if a new request is accepted, otherwise to IDLE.
- Latency:
  - Request in cycle 0: hilo_we is high in cycle WIDTH+3 (cycle 35 for WIDTH = 32).
  - Divide-by-zero case: hilo_we is high in cycle 2.
- Divide-by-zero result: hi = dividend exactly as presented (unsigned and signed alike), lo = all ones, dbz = 1.
- dbz updates only when a result is written. hi, lo and dbz hold their values between operations.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. No trap is raised.
- Stall:
  - stall = (req_valid | hilo_read) & (state is PREP, ITER or FIX), or hilo_read & (state == DONE).
  - MFHI/MFLO therefore never reads stale HI/LO.
- Flush:
  - In any non-IDLE state, go to IDLE on the next edge.
  - No hilo_we is issued; hi, lo and dbz are unchanged.
  - flush during DONE suppresses that cycle's hilo_we.
  - flush together with req_valid: the request is not accepted.
- req_valid while busy: ignored and not queued. The requester holds it under stall.

Decomposition:
- Package div_pkg:
  - state enum (IDLE, PREP, ITER, FIX, DONE).
  - DIV_WIDTH = 32.
  - Helper function for two's-complement magnitude.
- Sub-module div_iter_core:
  - Unsigned non-restoring step engine on the rising edge, with synchronous load and step inputs.
  - Holds the remainder, quotient and remainder-sign registers; exposes the quotient and corrected remainder.
  - Has no control of its own.

Test Plan:
- DIVU 100/7, accept in cycle 0 -> hilo_we only in cycle 35; lo = 14, hi = 2, dbz = 0; stall high in cycles 1-34 while req_valid is held.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 7 / 0xFFFFFFFE -> lo = 0xFFFFFFFD, hi = 1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0, dbz = 0.
- DIVU 5/0 -> hilo_we in cycle 2; hi = 5, lo = 0xFFFFFFFF, dbz = 1. The following DIVU 9/3 -> dbz = 0, lo = 3, hi = 0.
- flush in iteration 10 of DIVU 50/5 -> no hilo_we, hi/lo keep their prior values, req_ready = 1 on the next cycle.
- Back-to-back and reset:
  - DIVU 9/3 issued during DONE of a prior op -> accepted, completes 35 cycles later with lo = 3.
  - reset asserted mid-ITER -> hi = 0, lo = 0, req_ready = 1 immediately, with no clock edge needed.
